// File: rtl/ipif_regbank_pkg.sv
// ipif_regbank_pkg -- shared constants for the IPIF register bank.
//
// Holds the word offsets of every register in the map, the value returned
// by reads of unmapped words, and a byte-enable to bit-mask helper used by
// the RW registers and by the ISR write-one-to-clear path.
package ipif_regbank_pkg;

    localparam int unsigned REG_VERSION = 0;
    localparam int unsigned REG_SCRATCH = 1;
    localparam int unsigned REG_CTRL    = 2;
    localparam int unsigned REG_STATUS  = 3;
    localparam int unsigned REG_ISR     = 4;
    localparam int unsigned REG_IER     = 5;
    localparam int unsigned REG_COUNTER = 6;

    localparam logic [31:0] UNMAPPED_RD_DATA = 32'h0000_0000;

    // Expand the four byte enables into a 32-bit mask, one byte per enable.
    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        logic [31:0] mask;
        for (int i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/ipif_regbank_if.sv
// ipif_regbank_if -- register-access bus of the IPIF register bank.
//
// Write channel: wr_addr (word address), wr_req (1-cycle strobe),
//                wr_be (byte enables), wr_data, wr_ack (done, 1 cycle later).
// Read channel:  rd_addr (word address), rd_req (1-cycle strobe),
//                rd_data (valid only with rd_ack), rd_ack (1 cycle later).
// Modports: master drives requests, slave (the register bank) answers.
interface ipif_regbank_if #(
    parameter int C_ADDR_WIDTH = 12
);
    logic [C_ADDR_WIDTH-3:0] wr_addr;
    logic                    wr_req;
    logic [3:0]              wr_be;
    logic [31:0]             wr_data;
    logic                    wr_ack;

    logic [C_ADDR_WIDTH-3:0] rd_addr;
    logic                    rd_req;
    logic [31:0]             rd_data;
    logic                    rd_ack;

    modport master (
        output wr_addr, wr_req, wr_be, wr_data, rd_addr, rd_req,
        input  wr_ack, rd_data, rd_ack
    );

    modport slave (
        input  wr_addr, wr_req, wr_be, wr_data, rd_addr, rd_req,
        output wr_ack, rd_data, rd_ack
    );
endinterface

// File: rtl/ipif_regbank_irq.sv
// ipif_regbank_irq -- interrupt status logic of the IPIF register bank.
//
// Ports:
//   aclk, aresetn  clock and asynchronous active-low reset
//   irq_src_i      level interrupt sources
//   isr_clr_i      per-bit clear request (already qualified by the ISR write)
//   ier_i          interrupt enables
//   isr_o          interrupt status register
//   irq_o          registered |(ISR & IER)
//
// A bit of ISR sets on a rising edge of its source; a clear and a new edge
// in the same cycle leave the bit set so no event is lost.
module ipif_regbank_irq #(
    parameter int C_IRQ_NUM = 8
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [C_IRQ_NUM-1:0] irq_src_i,
    input  logic [C_IRQ_NUM-1:0] isr_clr_i,
    input  logic [C_IRQ_NUM-1:0] ier_i,
    output logic [C_IRQ_NUM-1:0] isr_o,
    output logic                 irq_o
);

    logic [C_IRQ_NUM-1:0] src_prev_q;
    logic [C_IRQ_NUM-1:0] isr_q, isr_d;
    logic                 irq_q, irq_d;
    logic [C_IRQ_NUM-1:0] rise;

    // NOTE: combinational blocks assign every output a default first, so no
    // path through them can leave a signal unassigned and infer a latch.
    always_comb begin
        rise  = irq_src_i & ~src_prev_q;
        isr_d = (isr_q & ~isr_clr_i) | rise;
        irq_d = |(isr_q & ier_i);
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            // All ones: a source already high when reset releases is not an edge.
            src_prev_q <= '1;
            isr_q      <= '0;
            irq_q      <= 1'b0;
        end else begin
            src_prev_q <= irq_src_i;
            isr_q      <= isr_d;
            irq_q      <= irq_d;
        end
    end

    assign isr_o = isr_q;
    assign irq_o = irq_q;

endmodule

// File: rtl/ipif_regbank.sv
// ipif_regbank -- small memory-mapped register bank behind an IPIF-style bus.
//
// Ports:
//   aclk, aresetn  clock and asynchronous active-low reset
//   bus            ipif_regbank_if.slave (write and read channels)
//   ctrl           CTRL register contents
//   status         live status, sampled by STATUS reads
//   irq_src        level interrupt sources
//   irq            interrupt request
//
// Map (word): 0 VERSION RO, 1 SCRATCH RW, 2 CTRL RW, 3 STATUS RO, 4 ISR W1C,
// 5 IER RW, 6 COUNTER RO (only when IPIF_REGBANK_COUNTER_EN is defined;
// otherwise word 6 is unmapped). Reads see register values from before a
// write in the same cycle.
module ipif_regbank
    import ipif_regbank_pkg::*;
#(
    parameter int          C_ADDR_WIDTH = 12,
    parameter int          C_DATA_WIDTH = 32,  // only 32 is supported
    parameter int          C_IRQ_NUM    = 8,   // 1..32
    parameter logic [31:0] C_VERSION    = 32'h0001_0000
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    ipif_regbank_if.slave           bus,
    output logic [C_DATA_WIDTH-1:0] ctrl,
    input  logic [C_DATA_WIDTH-1:0] status,
    input  logic [C_IRQ_NUM-1:0]    irq_src,
    output logic                    irq
);

    localparam int AW = C_ADDR_WIDTH - 2;

    localparam logic [AW-1:0] A_VERSION = AW'(REG_VERSION);
    localparam logic [AW-1:0] A_SCRATCH = AW'(REG_SCRATCH);
    localparam logic [AW-1:0] A_CTRL    = AW'(REG_CTRL);
    localparam logic [AW-1:0] A_STATUS  = AW'(REG_STATUS);
    localparam logic [AW-1:0] A_ISR     = AW'(REG_ISR);
    localparam logic [AW-1:0] A_IER     = AW'(REG_IER);

    logic [C_DATA_WIDTH-1:0] scratch_q, scratch_d;
    logic [C_DATA_WIDTH-1:0] ctrl_q,    ctrl_d;
    logic [C_DATA_WIDTH-1:0] ier_q,     ier_d;
    logic [C_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                    wr_ack_q, rd_ack_q;

    logic [C_DATA_WIDTH-1:0] wr_mask;
    logic [C_IRQ_NUM-1:0]    isr;
    logic [C_IRQ_NUM-1:0]    isr_clr;

    assign wr_mask = be_to_mask(bus.wr_be);

    // W1C: only written ones in enabled bytes clear ISR bits.
    assign isr_clr = (bus.wr_req && bus.wr_addr == A_ISR)
                   ? C_IRQ_NUM'(bus.wr_data & wr_mask) : '0;

`ifdef IPIF_REGBANK_COUNTER_EN
    localparam logic [AW-1:0] A_COUNTER = AW'(REG_COUNTER);

    logic [31:0] counter_q, counter_d;

    // Free-running; wraps naturally at 32 bits and is never written.
    assign counter_d = counter_q + 32'd1;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) counter_q <= '0;
        else          counter_q <= counter_d;
    end
`endif

    // Byte-enabled updates of the RW registers.
    always_comb begin
        scratch_d = scratch_q;
        ctrl_d    = ctrl_q;
        ier_d     = ier_q;
        if (bus.wr_req) begin
            case (bus.wr_addr)
                A_SCRATCH: scratch_d = (scratch_q & ~wr_mask) | (bus.wr_data & wr_mask);
                A_CTRL:    ctrl_d    = (ctrl_q    & ~wr_mask) | (bus.wr_data & wr_mask);
                A_IER:     ier_d     = (ier_q     & ~wr_mask) | (bus.wr_data & wr_mask);
                default:   ;  // RO and unmapped writes are acked and dropped
            endcase
        end
    end

    // Read mux works on current register values, giving read-old-value on
    // a same-cycle write. rd_data is zero outside the ack cycle.
    always_comb begin
        rd_data_d = '0;
        if (bus.rd_req) begin
            case (bus.rd_addr)
                A_VERSION: rd_data_d = C_VERSION;
                A_SCRATCH: rd_data_d = scratch_q;
                A_CTRL:    rd_data_d = ctrl_q;
                A_STATUS:  rd_data_d = status;
                A_ISR:     rd_data_d = C_DATA_WIDTH'(isr);
                A_IER:     rd_data_d = ier_q;
`ifdef IPIF_REGBANK_COUNTER_EN
                A_COUNTER: rd_data_d = counter_q;
`endif
                default:   rd_data_d = UNMAPPED_RD_DATA;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            scratch_q <= '0;
            ctrl_q    <= '0;
            ier_q     <= '0;
            rd_data_q <= '0;
            wr_ack_q  <= 1'b0;
            rd_ack_q  <= 1'b0;
        end else begin
            scratch_q <= scratch_d;
            ctrl_q    <= ctrl_d;
            ier_q     <= ier_d;
            rd_data_q <= rd_data_d;
            wr_ack_q  <= bus.wr_req;
            rd_ack_q  <= bus.rd_req;
        end
    end

    ipif_regbank_irq #(
        .C_IRQ_NUM (C_IRQ_NUM)
    ) u_irq (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .irq_src_i (irq_src),
        .isr_clr_i (isr_clr),
        .ier_i     (ier_q[C_IRQ_NUM-1:0]),
        .isr_o     (isr),
        .irq_o     (irq)
    );

    assign bus.wr_ack  = wr_ack_q;
    assign bus.rd_ack  = rd_ack_q;
    assign bus.rd_data = rd_data_q;
    assign ctrl        = ctrl_q;

endmodule

// File: tb/tb_ipif_regbank.sv
// tb_ipif_regbank -- self-checking bench for ipif_regbank.
//
// A register-map model (plain variables, updated once per clock from the
// applied inputs) predicts acks, rd_data, ctrl and irq; a negedge process
// compares them every cycle. Directed vectors add literal expectations.
// Honors IPIF_REGBANK_COUNTER_EN like the design.
module tb_ipif_regbank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ctrl;
    logic [31:0] status;
    logic [7:0]  irq_src;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    ipif_regbank_if #(.C_ADDR_WIDTH(12)) bus ();

    ipif_regbank #(
        .C_ADDR_WIDTH (12),
        .C_DATA_WIDTH (32),
        .C_IRQ_NUM    (8),
        .C_VERSION    (32'h0001_0000)
    ) dut (
        .aclk    (clk),
        .aresetn (rst_n),
        .bus     (bus),
        .ctrl    (ctrl),
        .status  (status),
        .irq_src (irq_src),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    // Model state
    logic [31:0] m_scratch = '0, m_ctrl = '0, m_ier = '0, m_isr = '0, m_cnt = '0;
    logic [7:0]  m_prev = '1;
    logic        exp_wr_ack = 1'b0, exp_rd_ack = 1'b0, exp_irq = 1'b0;
    logic [31:0] exp_rd_data = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mask_of(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = be[i] ? 8'hFF : 8'h00;
        return m;
    endfunction

    function automatic logic [31:0] mread(input logic [9:0] a);
        case (a)
            10'd0:   return 32'h0001_0000;
            10'd1:   return m_scratch;
            10'd2:   return m_ctrl;
            10'd3:   return status;
            10'd4:   return m_isr;
            10'd5:   return m_ier;
`ifdef IPIF_REGBANK_COUNTER_EN
            10'd6:   return m_cnt;
`endif
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_scratch = '0; m_ctrl = '0; m_ier = '0; m_isr = '0; m_cnt = '0;
        m_prev = '1;
        exp_wr_ack = 1'b0; exp_rd_ack = 1'b0; exp_irq = 1'b0; exp_rd_data = '0;
    endtask

    // One clock: the model consumes the inputs applied this cycle, then
    // returns 1 time unit after the edge so new inputs stay clear of it.
    task automatic tick();
        logic [31:0] msk;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            exp_wr_ack  = bus.wr_req;
            exp_rd_ack  = bus.rd_req;
            exp_rd_data = bus.rd_req ? mread(bus.rd_addr) : 32'h0;
            exp_irq     = |(m_isr & m_ier);
            if (bus.wr_req) begin
                msk = mask_of(bus.wr_be);
                case (bus.wr_addr)
                    10'd1: m_scratch = (m_scratch & ~msk) | (bus.wr_data & msk);
                    10'd2: m_ctrl    = (m_ctrl    & ~msk) | (bus.wr_data & msk);
                    10'd4: m_isr     = m_isr & ~(bus.wr_data & msk);
                    10'd5: m_ier     = (m_ier     & ~msk) | (bus.wr_data & msk);
                    default: ;
                endcase
            end
            m_isr  = m_isr | {24'h0, irq_src & ~m_prev};
            m_prev = irq_src;
            m_cnt  = m_cnt + 32'd1;
        end
        #1;
    endtask

    task automatic wr(input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
        bus.wr_addr = a; bus.wr_be = be; bus.wr_data = d; bus.wr_req = 1'b1;
        tick();
        bus.wr_req = 1'b0;
    endtask

    task automatic rd(input logic [9:0] a);
        bus.rd_addr = a; bus.rd_req = 1'b1;
        tick();
        bus.rd_req = 1'b0;
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        check("wr_ack",  {31'h0, bus.wr_ack}, {31'h0, exp_wr_ack});
        check("rd_ack",  {31'h0, bus.rd_ack}, {31'h0, exp_rd_ack});
        check("rd_data", bus.rd_data, exp_rd_data);
        check("ctrl",    ctrl, m_ctrl);
        check("irq",     {31'h0, irq}, {31'h0, exp_irq});
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected end before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] c0;
        rst_n = 1'b1;
        bus.wr_req = 1'b0; bus.rd_req = 1'b0;
        bus.wr_addr = '0; bus.rd_addr = '0; bus.wr_be = '0; bus.wr_data = '0;
        status  = 32'h0;
        irq_src = 8'h01;  // already high across reset release
        #2;
        rst_n = 1'b0;
        model_reset();
        repeat (3) tick();
        check("rst_irq",  {31'h0, irq}, 32'h0);
        check("rst_ctrl", ctrl, 32'h0);
        rst_n = 1'b1;
        tick();

        // Reset-state reads
        rd(10'd0);
        check("ver_ack",  {31'h0, bus.rd_ack}, 32'h1);
        check("ver_data", bus.rd_data, 32'h0001_0000);
        rd(10'd2);
        check("ctrl_rst_rd", bus.rd_data, 32'h0);
        tick();
        check("rd_data_idle", bus.rd_data, 32'h0);

        // SCRATCH byte enables
        wr(10'd1, 4'hF, 32'hA5A5_A5A5);
        check("wr_ack1", {31'h0, bus.wr_ack}, 32'h1);
        wr(10'd1, 4'b0101, 32'h1234_5678);
        check("wr_ack2", {31'h0, bus.wr_ack}, 32'h1);
        rd(10'd1);
        check("scratch_be", bus.rd_data, 32'hA534_A578);

        // RO write ignored, unmapped reads, live status
        wr(10'd0, 4'hF, 32'hDEAD_BEEF);
        rd(10'd0);
        check("ver_ro", bus.rd_data, 32'h0001_0000);
        rd(10'd7);
        check("unmapped7", bus.rd_data, 32'h0);
        rd(10'h3FF);
        check("unmapped_top", bus.rd_ack ? bus.rd_data : 32'hFFFF_FFFF, 32'h0);
        status = 32'hCAFE_0001;
        rd(10'd3);
        status = 32'h0;
        check("status", bus.rd_data, 32'hCAFE_0001);
        rd(10'd4);
        check("isr_no_rst_edge", bus.rd_data, 32'h0);

        // Interrupts
        wr(10'd5, 4'hF, 32'h0000_0008);
        irq_src = 8'h09; tick();
        irq_src = 8'h01; tick();
        check("irq_set", {31'h0, irq}, 32'h1);
        rd(10'd4);
        check("isr_set", bus.rd_data, 32'h8);
        wr(10'd4, 4'b1110, 32'h0000_0008);
        rd(10'd4);
        check("isr_be_off", bus.rd_data, 32'h8);
        wr(10'd4, 4'hF, 32'h0000_0008);
        check("irq_lag", {31'h0, irq}, 32'h1);
        tick();
        check("irq_clr", {31'h0, irq}, 32'h0);
        rd(10'd4);
        check("isr_clr", bus.rd_data, 32'h0);
        irq_src = 8'h09; tick();
        irq_src = 8'h01; tick();
        irq_src = 8'h09;
        wr(10'd4, 4'hF, 32'h0000_0008);
        irq_src = 8'h01;
        rd(10'd4);
        check("isr_clr_vs_edge", bus.rd_data, 32'h8);

        // Simultaneous write and read of CTRL
        bus.rd_addr = 10'd2; bus.rd_req = 1'b1;
        wr(10'd2, 4'hF, 32'h0000_00FF);
        bus.rd_req = 1'b0;
        check("sim_wr_ack", {31'h0, bus.wr_ack}, 32'h1);
        check("sim_rd_ack", {31'h0, bus.rd_ack}, 32'h1);
        check("sim_rd_old", bus.rd_data, 32'h0);
        check("sim_ctrl",   ctrl, 32'h0000_00FF);

        // Request coinciding with reset assertion
        bus.rd_addr = 10'd0; bus.rd_req = 1'b1;
        bus.wr_addr = 10'd1; bus.wr_be = 4'hF; bus.wr_data = 32'h5555_5555; bus.wr_req = 1'b1;
        rst_n = 1'b0;
        model_reset();
        tick();
        bus.rd_req = 1'b0; bus.wr_req = 1'b0;
        rst_n = 1'b1;
        tick();
        check("rst_req_rd_ack", {31'h0, bus.rd_ack}, 32'h0);
        check("rst_req_wr_ack", {31'h0, bus.wr_ack}, 32'h0);
        rd(10'd1);
        check("scratch_rst", bus.rd_data, 32'h0);

`ifdef IPIF_REGBANK_COUNTER_EN
        rd(10'd6);
        c0 = bus.rd_data;
        repeat (9) tick();
        rd(10'd6);
        check("cnt_delta", bus.rd_data - c0, 32'd10);
        force dut.counter_q = 32'hFFFF_FFFF;
        #1;
        release dut.counter_q;
        m_cnt = 32'hFFFF_FFFF;
        rd(10'd6);
        check("cnt_max", bus.rd_data, 32'hFFFF_FFFF);
        rd(10'd6);
        check("cnt_wrap", bus.rd_data, 32'h0);
`else
        c0 = 32'h0;
        rd(10'd6);
        check("cnt_absent", bus.rd_data, c0);
`endif
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ipif_regbank.md
IPIF_REGBANK -- requirements
Module: ipif_regbank

Interface
REQ-001 Parameter C_ADDR_WIDTH, default 12, sets the byte-address width; word address width is C_ADDR_WIDTH-2.
REQ-002 Parameter C_DATA_WIDTH, default 32, sets the data width; only 32 is supported.
REQ-003 Parameter C_IRQ_NUM, default 8, range 1..32, sets the number of interrupt sources.
REQ-004 Parameter C_VERSION, default 32'h0001_0000, sets the value returned by the VERSION register.
REQ-005 Ports: aclk  in  1  single clock; all logic is in this domain.
REQ-006 Ports: aresetn  in  1  asynchronous active-low reset.
REQ-007 Ports: wr_addr  in  C_ADDR_WIDTH-2  word address; wr_req  in  1  write strobe; wr_be  in  4  byte enables; wr_data  in  32  write data; wr_ack  out  1  write done.
REQ-008 Ports: rd_addr  in  C_ADDR_WIDTH-2  word address; rd_req  in  1  read strobe; rd_data  out  32  read data; rd_ack  out  1  read data valid.
REQ-009 Ports: ctrl  out  32  CTRL register contents; status  in  32  live status; irq_src  in  C_IRQ_NUM  level interrupt sources; irq  out  1  interrupt request.

Function
REQ-010 Register map (word address): 0 VERSION RO; 1 SCRATCH RW; 2 CTRL RW; 3 STATUS RO; 4 ISR W1C; 5 IER RW; 6 COUNTER RO (macro only).
REQ-011 wr_req and rd_req are single-cycle pulses; each req produces exactly one ack pulse one cycle later.
REQ-012 rd_data is registered, valid only in the rd_ack cycle, and driven to 0 at all other times.
REQ-013 RW writes update only the bytes whose wr_be bit is 1; writes to RO or unmapped addresses are acknowledged and ignored.
REQ-014 Reads of unmapped addresses return 32'h0000_0000 and are acknowledged.
REQ-015 STATUS reads return the status input sampled in the rd_req cycle.
REQ-016 ISR bit n is set on a rising edge of irq_src[n], detected against a registered copy of the previous value; ISR bits above C_IRQ_NUM-1 read 0.
REQ-017 A write of 1 to an enabled byte of ISR clears that bit; an edge event arriving in the same cycle as a clear leaves the bit set.
REQ-018 irq is registered and equals |(ISR & IER), one cycle after ISR or IER changes.
REQ-019 Simultaneous wr_req and rd_req are both serviced in the same cycle; a read of a register being written returns the old value.
REQ-020 ctrl reflects the CTRL register with no added latency after the write cycle.

Reset
REQ-021 On aresetn low: wr_ack=0, rd_ack=0, rd_data=0, irq=0, SCRATCH=0, CTRL=0 (ctrl=0), ISR=0, IER=0, COUNTER=0.
REQ-022 The irq_src previous-value register resets to all ones, so sources already high at reset release do not set ISR.
REQ-023 A req coinciding with the assertion of reset is discarded and no ack follows.

Configuration
REQ-024 With IPIF_REGBANK_COUNTER_EN defined: COUNTER at word 6 is a 32-bit free-running count that increments every aclk, wraps from 32'hFFFF_FFFF to 0, and ignores writes.
REQ-025 Without IPIF_REGBANK_COUNTER_EN: no counter logic exists and word 6 behaves as unmapped.

Structure
REQ-026 Package ipif_regbank_pkg holds the register word-offset constants and the unmapped-read value.
REQ-027 The interrupt logic (edge detect, ISR, W1C, irq) is the sub-module ipif_regbank_irq; decode and acks stay in the top.

Verification
REQ-028 After reset, read word 0 -> rd_ack one cycle later with rd_data=32'h0001_0000; read word 2 -> 0; irq=0.
REQ-029 Write SCRATCH 32'hA5A5_A5A5 with be=4'hF, then 32'h1234_5678 with be=4'b0101 -> read returns 32'hA534_A578; each write is acked after 1 cycle.
REQ-030 Pulse irq_src[3] high with IER=32'h8 -> ISR=32'h8 and irq=1; write ISR 32'h8 -> ISR=0 and irq=0 one cycle later; clear in the same cycle as a new edge -> bit stays set.
REQ-031 Simultaneous write CTRL=32'hFF and read CTRL in the same cycle -> both acks are returned, read gives the old value 0, and ctrl=32'hFF after the write.
REQ-032 With the macro, two reads of word 6 issued 10 cycles apart differ by 10; force the count to 32'hFFFF_FFFF -> next value is 0. Without the macro, word 6 reads 0.
